mul_add_seq: RTL and testbench

//  Sequential shift-add multiply-accumulate: P = Q*B + R, unsigned. Inverse of the

---
 rtl/mul_add_seq.sv | 90 +++++++++
 tb/tb_mul_add_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate, P = Q*B + R (unsigned), one multiplier bit per cycle.
// Optional MUL_ADD_EARLY_EXIT_EN: leave MUL as soon as the remaining multiplier bits are all zero.
module mul_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   Q_IN,
  input  logic [WIDTH-1:0]   B_IN,
  input  logic [WIDTH-1:0]   R_IN,
  output logic [2*WIDTH-1:0] P_OUT,
  output logic               valid,
  output logic               busy,
  output logic [1:0]         STATE_OUT
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mplier, mplier_sh;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CW-1:0]      cnt;
  logic               last;

  assign mplier_sh = mplier >> 1;
  assign STATE_OUT = state;

  always_comb begin
`ifdef MUL_ADD_EARLY_EXIT_EN
    last = (cnt == CW'(WIDTH-1)) || (mplier_sh == '0);
`else
    last = (cnt == CW'(WIDTH-1));
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = MUL;
      MUL:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      P_OUT  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nx;
      // busy tracks the registered state so it is high exactly in MUL and DONE
      busy  <= (state_nx != IDLE);
      valid <= 1'b0;
      case (state)
        IDLE: if (en) begin
          mplier <= Q_IN;
          mcand  <= {{WIDTH{1'b0}}, B_IN};
          acc    <= {{WIDTH{1'b0}}, R_IN};
          cnt    <= '0;
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          P_OUT <= acc;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed cases plus randomized round-trip
// triples against an arithmetic reference (P = Q*B + R, latency from multiplier bit count).
module tb_mul_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] Q_IN = '0, B_IN = '0, R_IN = '0;
  logic [7:0] P_OUT;
  logic       valid, busy;
  logic [1:0] STATE_OUT;

  logic        en8 = 1'b0;
  logic [7:0]  Q8 = '0, B8 = '0, R8 = '0;
  logic [15:0] P8;
  logic        valid8, busy8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_add_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Q_IN(Q_IN), .B_IN(B_IN), .R_IN(R_IN),
    .P_OUT(P_OUT), .valid(valid), .busy(busy), .STATE_OUT(STATE_OUT)
  );

  mul_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .Q_IN(Q8), .B_IN(B8), .R_IN(R8),
    .P_OUT(P8), .valid(valid8), .busy(busy8), .STATE_OUT(state8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Number of MUL iterations the reference expects for multiplier q.
  function automatic int iters(input int q, input int w);
`ifdef MUL_ADD_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < w; i++) if (q[i]) n = i + 1;
    return n;
`else
    return w;
`endif
  endfunction

  // Start one operation; optionally disturb en/Q_IN/B_IN at edge k+2.
  task automatic run_op(input int q, input int b, input int r, input bit disturb, input string tag);
    int lat, seen;
    lat  = iters(q, 4);
    seen = 0;
    @(negedge clk);
    Q_IN = 4'(q); B_IN = 4'(b); R_IN = 4'(r); en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_state0"}, STATE_OUT, 1);
    for (int i = 1; i <= lat + 3; i++) begin
      @(posedge clk); #1;
      if (disturb && i == 2) begin
        en = 1'b1; Q_IN = 4'd2; B_IN = 4'd2;
      end
      if (disturb && i == 3) en = 1'b0;
      if (valid) begin
        seen = i;
        break;
      end
      check({tag, "_busy"}, busy, 1);
    end
    check({tag, "_lat"}, seen, lat + 1);
    check({tag, "_p"}, P_OUT, q * b + r);
    check({tag, "_busyv"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_v1cyc"}, valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int q, b, r, seen;

    #12;
    check("rst_p", P_OUT, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", STATE_OUT, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_noen", STATE_OUT, 0);

    run_op(13, 11, 7, 1'b0, "t1");
    run_op(15, 15, 15, 1'b0, "t2max");
    run_op(0, 9, 5, 1'b0, "t3q0");
    run_op(8, 3, 0, 1'b0, "t3q8");
    run_op(1, 12, 3, 1'b0, "t3q1");
    run_op(6, 7, 1, 1'b1, "t4chg");

    // WIDTH=8 maximum operands
    @(negedge clk);
    Q8 = 8'd255; B8 = 8'd255; R8 = 8'd255; en8 = 1'b1;
    @(posedge clk); #1;
    en8 = 1'b0;
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (valid8) begin
        seen = i;
        break;
      end
    end
    check("w8_lat", seen, iters(255, 8) + 1);
    check("w8_p", P8, 65280);

    // Reset mid-operation after a non-zero result is already held
    @(negedge clk);
    Q_IN = 4'd9; B_IN = 4'd9; R_IN = 4'd0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_p", P_OUT, 0);
    check("t5_valid", valid, 0);
    check("t5_busy", busy, 0);
    check("t5_state", STATE_OUT, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid || busy) seen = 1;
    end
    check("t5_quiet", seen, 0);
    run_op(9, 9, 0, 1'b0, "t5re");

    // Round trip: divider outputs (Q, R<B) must rebuild the dividend
    for (int n = 0; n < 1000; n++) begin
      b = int'($urandom_range(1, 15));
      q = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, b - 1));
      run_op(q, b, r, 1'b0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1, expected 0");
    $fatal(1);
  end

endmodule
